// File: rtl/sample_frame_packer_pkg.sv
// Shared definitions for the sample frame packer: frame header byte, FSM states,
// and a saturating counter helper.
package sample_frame_packer_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_MSB  = 3'd2,
        ST_LSB  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sample_frame_packer_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and an occupancy count.
// Written to be reusable by other ADDA stages.
module sync_fifo
    import sample_frame_packer_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rptr_q];
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;

    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/sample_frame_packer.sv
// Buffers signed samples and emits frames: 0xA5 | FRAME_LEN x (MSB, LSB) | XOR checksum.
// busy mirrors FIFO full; samples arriving while full are counted in drop_cnt.
module sample_frame_packer
    import sample_frame_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_AW    = 4,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [15:0]           drop_cnt
);

    localparam logic [FIFO_AW:0] FRAME_LEN_W = (FIFO_AW+1)'(FRAME_LEN);

    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full, fifo_empty, fifo_rd_en, pop_req;
    logic [FIFO_AW:0]      fifo_count;
    logic [15:0]           sample_w;

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d, csum_q, csum_d, csum_lsb;
    logic             tx_valid_q, tx_valid_d, hs;
    logic [15:0]      hold_q, hold_d, drop_q, drop_d;
    logic [FIFO_AW:0] sent_q, sent_d;

    sync_fifo #(.WIDTH(DATA_WIDTH), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign sample_w   = 16'(signed'(fifo_rd_data));
    assign hs         = tx_valid_q & tx_ready;
    assign fifo_rd_en = pop_req & ~fifo_empty;
    assign busy       = fifo_full;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        hold_d     = hold_q;
        csum_d     = csum_q;
        sent_d     = sent_q;
        pop_req    = 1'b0;
        csum_lsb   = csum_q ^ hold_q[7:0];
        drop_d     = (in_valid & fifo_full) ? sat_inc16(drop_q) : drop_q;
        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (fifo_count >= FRAME_LEN_W) begin
                    state_d    = ST_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = FRAME_HDR;
                end
            end
            ST_HDR: if (hs) begin
                pop_req   = 1'b1;
                hold_d    = sample_w;
                csum_d    = 8'h00;
                sent_d    = (FIFO_AW+1)'(1);
                tx_data_d = sample_w[15:8];
                state_d   = ST_MSB;
            end
            ST_MSB: if (hs) begin
                csum_d    = csum_q ^ hold_q[15:8];
                tx_data_d = hold_q[7:0];
                state_d   = ST_LSB;
            end
            ST_LSB: if (hs) begin
                csum_d = csum_lsb;
                if (sent_q < FRAME_LEN_W) begin
                    pop_req   = 1'b1;
                    hold_d    = sample_w;
                    sent_d    = sent_q + 1'b1;
                    tx_data_d = sample_w[15:8];
                    state_d   = ST_MSB;
                end else begin
                    tx_data_d = csum_lsb;
                    state_d   = ST_CSUM;
                end
            end
            ST_CSUM: if (hs) begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            hold_q     <= 16'h0000;
            csum_q     <= 8'h00;
            sent_q     <= '0;
            drop_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
            sent_q     <= sent_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: reset, framing, backpressure, threshold,
// overflow and push/pop-at-full scenarios with hand-computed byte streams.
module tb_sample_frame_packer;

    localparam int DW = 14;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, tx_ready;
    logic [DW-1:0] in_data;
    logic          busy, tx_valid;
    logic [7:0]    tx_data;
    logic [15:0]   drop_cnt;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];
    int         smp[$];
    logic [7:0] exp2 [18] = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'hFE,
                              8'h1F, 8'hFF, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07};
    int         vec2 [8] = '{1, -1, 2, -2, 8191, -8192, 0, 5};

    sample_frame_packer #(.DATA_WIDTH(DW), .FIFO_AW(4), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .busy(busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = DW'(v);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int c = 0; c < budget && rx_q.size() < n; c++) tick;
    endtask

    function automatic void make_expected();
        logic [15:0] w;
        logic [7:0]  c;
        exp_q.delete();
        for (int f = 0; f < smp.size() / FL; f++) begin
            exp_q.push_back(8'hA5);
            c = 8'h00;
            for (int j = 0; j < FL; j++) begin
                w = 16'(smp[f*FL+j]);
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
                c = c ^ w[15:8] ^ w[7:0];
            end
            exp_q.push_back(c);
        end
    endfunction

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0;
        repeat (3) tick;
        total_cnt++; if ({tx_valid, tx_data, busy, drop_cnt} !== 26'h0)
            $display("FAIL reset_state got v=%b d=%h b=%b drop=%h want all 0", tx_valid, tx_data, busy, drop_cnt);
        else pass_cnt++;
        rst = 1'b1;
        tick;
        for (int i = 0; i < 17; i++) push(i);
        total_cnt++; if (drop_cnt !== 16'd1) $display("FAIL pre_reset_drop got %0d want 1", drop_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL pre_reset_busy got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
            $display("FAIL pre_reset_hdr got v=%b d=%h want 1/a5", tx_valid, tx_data);
        else pass_cnt++;
        #3 rst = 1'b0;
        #1;
        total_cnt++; if ({tx_valid, tx_data, busy, drop_cnt} !== 26'h0)
            $display("FAIL async_reset got v=%b d=%h b=%b drop=%h want all 0", tx_valid, tx_data, busy, drop_cnt);
        else pass_cnt++;
        tick;
        rst = 1'b1;
        repeat (3) tick;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL post_reset_idle got %b want 0", tx_valid); else pass_cnt++;
    endtask

    task automatic test_single_frame;
        rx_q.delete(); rx_cyc.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(vec2[i]);
        wait_bytes(18, 100);
        for (int i = 0; i < 18; i++) begin
            total_cnt++;
            if (i >= rx_q.size() || rx_q[i] !== exp2[i])
                $display("FAIL single_byte[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp2[i]);
            else pass_cnt++;
        end
        repeat (3) tick;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL single_idle got %b want 0", tx_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic       pv, pr;
        logic [7:0] pd;
        rx_q.delete(); rx_cyc.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(vec2[i]);
        for (int c = 0; c < 200 && rx_q.size() < 18; c++) begin
            tx_ready = (c % 3 == 0);
            pv = tx_valid; pd = tx_data; pr = tx_ready;
            tick;
            if (pv && !pr) begin
                total_cnt++;
                if (tx_valid !== 1'b1 || tx_data !== pd)
                    $display("FAIL bp_stable got v=%b d=%h want 1/%h", tx_valid, tx_data, pd);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 18; i++) begin
            total_cnt++;
            if (i >= rx_q.size() || rx_q[i] !== exp2[i])
                $display("FAIL bp_byte[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp2[i]);
            else pass_cnt++;
        end
        tx_ready = 1'b1;
        repeat (3) tick;
    endtask

    task automatic test_threshold;
        rx_q.delete(); rx_cyc.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(100 + i);
        repeat (3) tick;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL thr_7_samples got %b want 0", tx_valid); else pass_cnt++;
        in_valid = 1'b1; in_data = DW'(107);
        tick;
        in_valid = 1'b0;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL thr_1cyc got %b want 0", tx_valid); else pass_cnt++;
        tick;
        total_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
            $display("FAIL thr_2cyc got v=%b d=%h want 1/a5", tx_valid, tx_data);
        else pass_cnt++;
        wait_bytes(18, 100);
        total_cnt++; if (rx_q.size() !== 18) $display("FAIL thr_frame_len got %0d want 18", rx_q.size()); else pass_cnt++;
        repeat (3) tick;
    endtask

    task automatic test_overflow;
        rx_q.delete(); rx_cyc.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'(i*700 - 7000);
            tick;
            total_cnt++; if (busy !== (i >= 15))
                $display("FAIL ovf_busy[%0d] got %b want %b", i, busy, (i >= 15));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++; if (drop_cnt !== 16'd4) $display("FAIL ovf_drop got %0d want 4", drop_cnt); else pass_cnt++;
        smp.delete();
        for (int i = 0; i < 16; i++) smp.push_back(i*700 - 7000);
        make_expected();
        tx_ready = 1'b1;
        wait_bytes(36, 200);
        for (int i = 0; i < 36; i++) begin
            total_cnt++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
                $display("FAIL ovf_byte[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else pass_cnt++;
        end
        repeat (3) tick;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ovf_drained_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_push_pop_full;
        rx_q.delete(); rx_cyc.delete();
        tx_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_data = DW'(i);
            tick;
        end
        in_data = DW'(18); tx_ready = 1'b1;
        tick;
        in_data = DW'(19);
        tick;
        in_valid = 1'b0;
        for (int k = 20; k < 35; k++) begin
            tick; tick;
            in_valid = 1'b1; in_data = DW'(k);
            tick;
            in_valid = 1'b0;
        end
        wait_bytes(72, 300);
        total_cnt++; if (drop_cnt !== 16'd7) $display("FAIL ppf_drop got %0d want 7", drop_cnt); else pass_cnt++;
        smp.delete();
        for (int i = 0; i < 16; i++) smp.push_back(i);
        for (int i = 19; i < 35; i++) smp.push_back(i);
        make_expected();
        for (int i = 0; i < 72; i++) begin
            total_cnt++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
                $display("FAIL ppf_byte[%0d] got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else pass_cnt++;
        end
        for (int f = 1; f < 4; f++) begin
            total_cnt++;
            if (rx_cyc.size() < 72 || rx_cyc[18*f] - rx_cyc[18*f-1] !== 2)
                $display("FAIL ppf_gap[%0d] got %0d want 2", f,
                         (rx_cyc.size() >= 72) ? rx_cyc[18*f] - rx_cyc[18*f-1] : -1);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_backpressure;
        test_threshold;
        test_overflow;
        test_push_pop_full;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
